// File: rtl/accum_seq_pkg.sv
// accum_seq_pkg: shared state encoding and default widths for the accumulation sequencer
//   state_e   : INIT, IDLE, CLEAR, ACCUM, RESULT
//   DEF_WIDTH : default operand/result width
//   DEF_LEN_W : default job length field width
package accum_seq_pkg;
  typedef enum logic [2:0] {INIT, IDLE, CLEAR, ACCUM, RESULT} state_e;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_LEN_W = 8;
endpackage

// File: rtl/accumlator.sv
// accumlator: running-sum register with synchronous clear
//   clk    : clock
//   reset  : synchronous clear, wins over enable
//   enable : add in to the running sum this cycle
//   in     : operand
//   out    : running sum, wraps modulo 2^WIDTH
module accumlator #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);
  logic [WIDTH-1:0] out_q, out_d;
  always_comb out_d = reset ? '0 : enable ? out_q + in : out_q;
  always_ff @(posedge clk) out_q <= out_d;
  assign out = out_q;
endmodule

// File: rtl/accum_seq.sv
// accum_seq: job sequencer that sums exactly cmd_len streamed operands into a valid/ready result
//   clk, reset_n         : clock, async active-low reset
//   cmd_valid/ready/len  : job command handshake and operand count (0 legal)
//   abort                : drop the current job and return through INIT
//   in_valid/ready/data  : operand stream
//   res_valid/ready/data : job sum handshake
//   busy                 : high whenever not IDLE
module accum_seq
  import accum_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy
);
  state_e state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic acc_clr, acc_en;
  assign cmd_ready = state_q == IDLE && !abort;
  assign in_ready  = state_q == ACCUM && !abort;
  assign res_valid = state_q == RESULT;
  assign busy      = state_q != IDLE;
  assign acc_clr   = state_q == INIT || state_q == CLEAR;
  assign acc_en    = in_valid && in_ready;
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    case (state_q)
      INIT: state_d = IDLE;
      IDLE: begin
        if (abort) state_d = INIT;
        else if (cmd_valid) begin
          state_d = CLEAR;
          rem_d = cmd_len;
        end
      end
      CLEAR: state_d = abort ? INIT : rem_q != '0 ? ACCUM : RESULT;
      ACCUM: begin
        if (abort) state_d = INIT;
        else if (in_valid) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = RESULT;
        end
      end
      RESULT: state_d = abort ? INIT : res_ready ? IDLE : RESULT;
      default: state_d = INIT;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= INIT;
      rem_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
    end
  accumlator #(.WIDTH(WIDTH)) u_acc (
    .clk(clk),
    .reset(acc_clr),
    .enable(acc_en),
    .in(in_data),
    .out(res_data)
  );
endmodule

// File: tb/tb_accum_seq.sv
// tb_accum_seq: directed scoreboard bench for accum_seq
module tb_accum_seq;
  logic clk = 0, reset_n = 0;
  logic cmd_valid = 0, cmd_ready, abort = 0;
  logic [7:0] cmd_len = 0;
  logic in_valid = 0, in_ready;
  logic [31:0] in_data = 0;
  logic res_valid, res_ready = 0, busy;
  logic [31:0] res_data;
  logic [31:0] exp_q[$];
  logic [31:0] ops[$];
  int n_chk = 0, n_fail = 0;

  accum_seq dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (reset_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) chk("unexpected_result", res_valid, 1'b0);
      else chk("scoreboard_res_data", res_data, exp_q.pop_front());
    end

  task automatic wait_cmd();
    int n = 0;
    while (!cmd_ready && n < 20) begin
      step();
      n++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
  endtask

  task automatic run_job(input int len, input logic [31:0] exp, input int gap, input int hold);
    wait_cmd();
    cmd_valid = 1;
    cmd_len = len[7:0];
    exp_q.push_back(exp);
    step();
    cmd_valid = 0;
    @(negedge clk);
    chk("clear_in_ready", in_ready, 0);
    chk("clear_busy", busy, 1);
    step();
    for (int i = 0; i < len; i++) begin
      if (i > 0) repeat (gap) begin
        in_valid = 0;
        step();
      end
      in_valid = 1;
      in_data = ops[i];
      @(negedge clk);
      chk("accum_in_ready", in_ready, 1);
      step();
    end
    in_valid = 0;
    @(negedge clk);
    chk("res_latency_valid", res_valid, 1);
    chk("res_latency_data", res_data, exp);
    chk("res_in_ready", in_ready, 0);
    chk("res_cmd_ready", cmd_ready, 0);
    repeat (hold) begin
      step();
      @(negedge clk);
      chk("hold_res_valid", res_valid, 1);
      chk("hold_res_data", res_data, exp);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_cmd_ready", cmd_ready, 0);
    end
    step();
    res_ready = 1;
    @(negedge clk);
    step();
    res_ready = 0;
    @(negedge clk);
    chk("post_res_cmd_ready", cmd_ready, 1);
    chk("post_res_valid", res_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, n_chk %0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_busy", busy, 1);
    #6 reset_n = 1;
    @(negedge clk);
    chk("init_cmd_ready", cmd_ready, 0);
    chk("init_busy", busy, 1);
    step();
    @(negedge clk);
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_busy", busy, 0);
    step();
    ops = '{32'd1, 32'd2, 32'd3, 32'd4};
    run_job(4, 32'd10, 0, 0);
    ops = '{32'd5, 32'd0, 32'd7};
    run_job(3, 32'd12, 2, 0);
    ops = {};
    run_job(0, 32'd0, 0, 0);
    ops = '{32'hFFFF_FFFF, 32'h2};
    run_job(2, 32'h1, 0, 5);
    wait_cmd();
    cmd_valid = 1;
    cmd_len = 8'd4;
    step();
    cmd_valid = 0;
    step();
    in_valid = 1;
    in_data = 3;
    step();
    step();
    abort = 1;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 0);
    step();
    abort = 0;
    in_valid = 0;
    @(negedge clk);
    chk("abort_init_busy", busy, 1);
    chk("abort_init_cmd_ready", cmd_ready, 0);
    chk("abort_init_res_valid", res_valid, 0);
    step();
    @(negedge clk);
    chk("abort_idle_cmd_ready", cmd_ready, 1);
    step();
    ops = '{32'd9};
    run_job(1, 32'd9, 0, 0);
    wait_cmd();
    cmd_valid = 1;
    cmd_len = 8'd4;
    step();
    cmd_valid = 0;
    step();
    in_valid = 1;
    in_data = 5;
    step();
    step();
    in_valid = 0;
    #2 reset_n = 0;
    #1;
    chk("async_in_ready", in_ready, 0);
    chk("async_cmd_ready", cmd_ready, 0);
    chk("async_res_valid", res_valid, 0);
    chk("async_busy", busy, 1);
    step();
    #2 reset_n = 1;
    @(negedge clk);
    chk("reinit_cmd_ready", cmd_ready, 0);
    step();
    @(negedge clk);
    chk("reinit_idle_cmd_ready", cmd_ready, 1);
    step();
    ops = '{32'd4, 32'd6};
    run_job(2, 32'd10, 0, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
